// File: rtl/iq_amp_demod_pkg.sv
// Shared widths and helpers for the multi-channel I/Q amplitude demodulator.
// The localparams give the widths at the default parameter set.
package iq_demod_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int ch_width(input int channels);
      return (clog2(channels) < 1) ? 1 : clog2(channels);
   endfunction

   function automatic logic [63:0] abs_s64(input logic signed [63:0] x);
      return (x < 0) ? -x : x;
   endfunction

   localparam int CH_W  = ch_width(4);
   localparam int P_W   = 10 + 9;
   localparam int ACC_W = P_W + 6;
   localparam int MAG_W = ACC_W + 1;

endpackage

// File: rtl/iq_amp_demod_if.sv
// Sample-in / amplitude-out bundle for iq_amp_demod; the slave side is the demodulator.
interface iq_amp_demod_if #(
   parameter int WIDTH_DATA    = 10,
   parameter int WIDTH_SIN_COS = 9,
   parameter int CHANNELS      = 4,
   parameter int WIDTH_AMP     = 10
);
   localparam int CHW = iq_demod_pkg::ch_width(CHANNELS);

   logic                            en;
   logic [CHW-1:0]                  ch;
   logic [WIDTH_DATA-1:0]           data;
   logic signed [WIDTH_SIN_COS-1:0] sin;
   logic signed [WIDTH_SIN_COS-1:0] cos;
   logic                            sync;
   logic [WIDTH_AMP-1:0]            amp;
   logic [CHW-1:0]                  amp_ch;
   logic                            amp_valid;

   modport master (output en, ch, data, sin, cos, sync,
                   input  amp, amp_ch, amp_valid);
   modport slave  (input  en, ch, data, sin, cos, sync,
                   output amp, amp_ch, amp_valid);
endinterface

// File: rtl/iq_amp_demod_amp_approx_pipe.sv
// Two-stage alpha-max-beta-min magnitude of a completed I/Q block, scaled to the
// output width; the channel tag rides along with the data.
module amp_approx_pipe
   import iq_demod_pkg::*;
#(
   parameter int AW        = 25,
   parameter int WIDTH_AMP = 10,
   parameter int CHW       = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid_i,
   input  logic signed [AW-1:0] in_i_i,
   input  logic signed [AW-1:0] in_q_i,
   input  logic [CHW-1:0]       in_ch_i,
   output logic [WIDTH_AMP-1:0] amp_o,
   output logic [CHW-1:0]       amp_ch_o,
   output logic                 amp_valid_o
);
   localparam int MW = AW + 1;

   logic [AW-1:0]        a_d, b_d, a_q, b_q;
   logic                 s1_v_q;
   logic [CHW-1:0]       s1_ch_q;
   logic [AW-1:0]        mx, mn;
   logic [MW-1:0]        mag;
   logic [WIDTH_AMP-1:0] amp_d, amp_q;
   logic [CHW-1:0]       amp_ch_q;
   logic                 amp_v_q;

   always_comb begin
      a_d = AW'(abs_s64(64'(in_i_i)));
      b_d = AW'(abs_s64(64'(in_q_i)));
   end

   // 1 + 1/4 + 1/8 of the smaller component approximates sqrt(a^2 + b^2)
   always_comb begin
      mx  = (a_q >= b_q) ? a_q : b_q;
      mn  = (a_q >= b_q) ? b_q : a_q;
      mag = MW'(mx) + MW'(mn >> 2) + MW'(mn >> 3);
   end

   generate
      if (MW > WIDTH_AMP) begin : g_shift
         logic [MW-1:0] sh;
         assign sh    = mag >> (MW - WIDTH_AMP);
         assign amp_d = ((sh >> WIDTH_AMP) != '0) ? '1 : sh[WIDTH_AMP-1:0];
      end else begin : g_ext
         assign amp_d = WIDTH_AMP'(mag);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         s1_v_q   <= 1'b0;
         s1_ch_q  <= '0;
         amp_q    <= '0;
         amp_ch_q <= '0;
         amp_v_q  <= 1'b0;
      end else begin
         s1_v_q  <= in_valid_i;
         amp_v_q <= s1_v_q;
         if (in_valid_i) begin
            a_q     <= a_d;
            b_q     <= b_d;
            s1_ch_q <= in_ch_i;
         end
         if (s1_v_q) begin
            amp_q    <= amp_d;
            amp_ch_q <= s1_ch_q;
         end
      end
   end

   assign amp_o       = amp_q;
   assign amp_ch_o    = amp_ch_q;
   assign amp_valid_o = amp_v_q;
endmodule

// File: rtl/iq_amp_demod.sv
// Multi-channel synchronous I/Q demodulator: per-channel integrate-and-dump of
// sample*cos / sample*sin over 2**LOG2_N samples, then amplitude estimation.
module iq_amp_demod
   import iq_demod_pkg::*;
#(
   parameter int WIDTH_DATA    = 10,
   parameter int WIDTH_SIN_COS = 9,
   parameter int CHANNELS      = 4,
   parameter int LOG2_N        = 6,
   parameter int WIDTH_AMP     = 10
) (
   input logic           clk,
   input logic           rst,
   iq_amp_demod_if.slave bus
);
   localparam int CHW = ch_width(CHANNELS);
   localparam int PW  = WIDTH_DATA + WIDTH_SIN_COS;
   localparam int AW  = PW + LOG2_N;
   localparam logic [LOG2_N-1:0] CNT_LAST = '1;

   logic signed [WIDTH_DATA-1:0] smp;
   logic signed [PW-1:0]         prod_i, prod_q;
   logic signed [AW-1:0]         ext_i, ext_q;
   logic                         ch_ok;

   logic signed [AW-1:0] acc_i_d [CHANNELS];
   logic signed [AW-1:0] acc_i_q [CHANNELS];
   logic signed [AW-1:0] acc_q_d [CHANNELS];
   logic signed [AW-1:0] acc_q_q [CHANNELS];
   logic [LOG2_N-1:0]    cnt_d   [CHANNELS];
   logic [LOG2_N-1:0]    cnt_q   [CHANNELS];

   logic                 blk_v_d, blk_v_q;
   logic signed [AW-1:0] blk_i_d, blk_i_q, blk_q_d, blk_q_q;
   logic [CHW-1:0]       blk_ch_d, blk_ch_q;

   // Offset-binary to two's complement is just an MSB flip
   assign smp    = {~bus.data[WIDTH_DATA-1], bus.data[WIDTH_DATA-2:0]};
   assign prod_i = PW'(smp) * PW'(bus.cos);
   assign prod_q = PW'(smp) * PW'(bus.sin);
   assign ext_i  = AW'(prod_i);
   assign ext_q  = AW'(prod_q);
   assign ch_ok  = int'(bus.ch) < CHANNELS;

   always_comb begin
      acc_i_d  = acc_i_q;
      acc_q_d  = acc_q_q;
      cnt_d    = cnt_q;
      blk_v_d  = 1'b0;
      blk_i_d  = blk_i_q;
      blk_q_d  = blk_q_q;
      blk_ch_d = blk_ch_q;
      for (int c = 0; c < CHANNELS; c++) begin
         if (bus.sync) begin
            acc_i_d[c] = '0;
            acc_q_d[c] = '0;
            cnt_d[c]   = '0;
         end
         // sync is applied first so a coincident sample opens the new block
         if (bus.en && ch_ok && (bus.ch == CHW'(c))) begin
            if (cnt_d[c] == CNT_LAST) begin
               blk_v_d    = 1'b1;
               blk_i_d    = acc_i_d[c] + ext_i;
               blk_q_d    = acc_q_d[c] + ext_q;
               blk_ch_d   = bus.ch;
               acc_i_d[c] = '0;
               acc_q_d[c] = '0;
               cnt_d[c]   = '0;
            end else begin
               acc_i_d[c] = acc_i_d[c] + ext_i;
               acc_q_d[c] = acc_q_d[c] + ext_q;
               cnt_d[c]   = cnt_d[c] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            acc_i_q[c] <= '0;
            acc_q_q[c] <= '0;
            cnt_q[c]   <= '0;
         end
         blk_v_q  <= 1'b0;
         blk_i_q  <= '0;
         blk_q_q  <= '0;
         blk_ch_q <= '0;
      end else begin
         acc_i_q  <= acc_i_d;
         acc_q_q  <= acc_q_d;
         cnt_q    <= cnt_d;
         blk_v_q  <= blk_v_d;
         blk_i_q  <= blk_i_d;
         blk_q_q  <= blk_q_d;
         blk_ch_q <= blk_ch_d;
      end
   end

   amp_approx_pipe #(
      .AW        (AW),
      .WIDTH_AMP (WIDTH_AMP),
      .CHW       (CHW)
   ) u_pipe (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (blk_v_q),
      .in_i_i      (blk_i_q),
      .in_q_i      (blk_q_q),
      .in_ch_i     (blk_ch_q),
      .amp_o       (bus.amp),
      .amp_ch_o    (bus.amp_ch),
      .amp_valid_o (bus.amp_valid)
   );
endmodule
